// File: rtl/seg7_scan_scheduler_if.sv
// seg7_scan_scheduler_if: scan control inputs and registered display outputs of the digit scan scheduler.
interface seg7_scan_scheduler_if #(
  parameter int NDIG     = 4,
  parameter int BRIGHT_W = 4
);
  logic                    en;
  logic                    blank;
  logic [4*NDIG-1:0]       digits;
  logic [BRIGHT_W-1:0]     brightness;
  logic [3:0]              dig_val;
  logic [$clog2(NDIG)-1:0] dig_idx;
  logic [NDIG-1:0]         common;
  logic                    frame_start;
  modport master (
    output en, blank, digits, brightness,
    input  dig_val, dig_idx, common, frame_start
  );
  modport slave (
    input  en, blank, digits, brightness,
    output dig_val, dig_idx, common, frame_start
  );
endinterface

// File: rtl/seg7_scan_scheduler.sv
// seg7_scan_scheduler: multiplexes NDIG BCD digits with dead time, brightness duty and leading-zero blanking.
// Define SCAN_SKIP_BLANK_EN to advance straight past blanked leading digits and shorten the frame.
module seg7_scan_scheduler #(
  parameter int NDIG     = 4,
  parameter int SLOT_CYC = 16,
  parameter int DEAD_CYC = 2,
  parameter int BRIGHT_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  seg7_scan_scheduler_if.slave bus
);
  localparam int CW = $clog2(SLOT_CYC);
  localparam int IW = $clog2(NDIG);
  localparam int W  = (BRIGHT_W > CW ? BRIGHT_W : CW) + 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     slot_q, slot_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [NDIG-1:0]   common_q, common_d;
  logic [3:0]        dig_val_q, dig_val_d;
  logic              fs_q, fs_d;
  logic [NDIG:0]     blk_d;
  logic [IW:0]       nxt;
  logic              slot_end, frame_end, on;
  logic [W-1:0]      s_w;

  // Bit k set when digit k is a blanked leading zero; the extra top bit marks "past the last digit".
  function automatic logic [NDIG:0] lz_mask(input logic [4*NDIG-1:0] sh);
    logic [NDIG:0] m;
    logic          z;
    z       = 1'b1;
    m       = '0;
    m[NDIG] = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      z    = z & (sh[4*k+:4] == 4'd0);
      m[k] = z && (k != 0);
    end
    return m;
  endfunction

`ifdef SCAN_SKIP_BLANK_EN
  logic [NDIG:0] blk_q;
  assign blk_q = lz_mask(shadow_q);
`endif

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    fs_d     = 1'b0;
    nxt      = {1'b0, idx_q} + 1'b1;
    slot_end = slot_q == CW'(SLOT_CYC - 1);
`ifdef SCAN_SKIP_BLANK_EN
    frame_end = blk_q[nxt];
`else
    frame_end = nxt == (IW+1)'(NDIG);
`endif
    if (!bus.en) begin
      state_d = IDLE;
      slot_d  = '0;
      idx_d   = '0;
    end else if (state_q == IDLE || (slot_end && frame_end)) begin
      state_d  = SCAN;
      slot_d   = '0;
      idx_d    = '0;
      shadow_d = bus.digits;
      fs_d     = 1'b1;
    end else if (slot_end) begin
      slot_d = '0;
      idx_d  = nxt[IW-1:0];
    end else begin
      slot_d = slot_q + 1'b1;
    end
    blk_d     = lz_mask(shadow_d);
    s_w       = W'(slot_d);
    on        = state_d == SCAN && s_w >= W'(DEAD_CYC) && (s_w - W'(DEAD_CYC)) < W'(bus.brightness)
                && !bus.blank && !blk_d[{1'b0, idx_d}];
    common_d  = on ? NDIG'(1) << idx_d : '0;
    dig_val_d = state_d == SCAN ? 4'(shadow_d >> {idx_d, 2'b00}) : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      common_q  <= '0;
      dig_val_q <= '0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      common_q  <= common_d;
      dig_val_q <= dig_val_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.common      = common_q;
  assign bus.dig_val     = dig_val_q;
  assign bus.dig_idx     = idx_q;
  assign bus.frame_start = fs_q;
endmodule
